// File: rtl/i2s_pkg.sv
// Shared I2S constants and sample type, common to the transmitter and receiver.
// in_slot() marks the bit periods that carry audio once the one-bit I2S delay is applied.
package i2s_pkg;

  localparam int DOWNSAMPLE = 4;
  localparam int BITS       = 32;
  localparam int PCM_W      = 16;

  typedef struct packed {
    logic [PCM_W-1:0] left;
    logic [PCM_W-1:0] right;
  } stereo_t;

  // Audio bits sit one bclk after each lrclk edge; every other bit period is padding.
  function automatic logic in_slot(input int idx, input int bits, input int pcm_w);
    return ((idx >= 1) && (idx <= pcm_w)) ||
           ((idx >= bits + 1) && (idx <= bits + pcm_w));
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Show-ahead sample FIFO for the I2S transmitter.
// ready is registered from the next occupancy, so it never depends on a same-cycle pop.
module pcm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt != FULL_CNT);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: derives bclk/lrclk from clk_gen_fast and serialises buffered stereo samples.
// Outputs are registered from next-state values so bclk falls together with lrclk/sdata changes.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DOWNSAMPLE = i2s_pkg::DOWNSAMPLE,
  parameter int BITS       = i2s_pkg::BITS,
  parameter int PCM_W      = i2s_pkg::PCM_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_gen_fast,
  input  logic               arstn,
  input  logic [2*PCM_W-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               mute,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               underrun,
  output logic [15:0]        underrun_cnt
);

  localparam int PH_W = $clog2(DOWNSAMPLE);
  localparam int BC_W = $clog2(2 * BITS);
  localparam int SR_W = 2 * PCM_W;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(DOWNSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(DOWNSAMPLE / 2);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(2 * BITS - 1);
  localparam logic [BC_W-1:0] BIT_RIGHT = BC_W'(BITS);

  logic [PH_W-1:0] ph_cnt;
  logic [PH_W-1:0] ph_nxt;
  logic [BC_W-1:0] bit_cnt;
  logic [BC_W-1:0] bit_nxt;
  logic [SR_W-1:0] shreg;
  logic [SR_W-1:0] fifo_dout;
  logic            first_load;
  logic            bit_adv;
  logic            frame_load;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_pop;
  logic            push;

  // The first edge after reset release counts as a frame load so frame 0 reports its underrun.
  always_comb begin
    bit_adv    = (ph_cnt == PH_LAST);
    ph_nxt     = bit_adv ? '0 : ph_cnt + 1'b1;
    bit_nxt    = bit_cnt;
    if (bit_adv) bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    frame_load = first_load || (bit_adv && (bit_cnt == BIT_LAST));
    fifo_pop   = frame_load && !fifo_empty;
    push       = s_tvalid && s_tready && !fifo_full;
  end

  pcm_fifo #(
    .W     (SR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_gen_fast),
    .arstn (arstn),
    .push  (push),
    .pop   (fifo_pop),
    .din   (s_tdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (s_tready)
  );

  always_ff @(posedge clk_gen_fast or negedge arstn) begin
    if (!arstn) begin
      ph_cnt       <= '0;
      bit_cnt      <= '0;
      first_load   <= 1'b1;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      sdata        <= 1'b0;
      shreg        <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      ph_cnt     <= ph_nxt;
      bit_cnt    <= bit_nxt;
      first_load <= 1'b0;
      bclk       <= (ph_nxt >= PH_HALF);
      lrclk      <= (bit_nxt >= BIT_RIGHT);
      underrun   <= frame_load && fifo_empty;
      // Mute is sampled only here, so mid-frame changes cannot touch the frame in flight.
      if (frame_load) begin
        shreg <= (fifo_empty || mute) ? '0 : fifo_dout;
        sdata <= 1'b0;
        if (fifo_empty && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 1'b1;
      end else if (bit_adv) begin
        if (in_slot(int'(bit_nxt), BITS, PCM_W)) begin
          sdata <= shreg[SR_W-1];
          shreg <= shreg << 1;
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised and directed bench for i2s_tx, checked against a frame-level model of the I2S stream.
// The model predicts every output from the edge count since reset and a queue of accepted samples.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DS    = 4;
  localparam int NB    = 32;
  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = DS * 2 * NB;

  logic          clk_gen_fast = 1'b0;
  logic          arstn = 1'b0;
  logic [2*PW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          mute = 1'b0;
  logic          s_tready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [2*PW-1:0] q[$];
  logic [2*PW-1:0] cur_frame = '0;
  int              n = 0;
  logic            exp_underrun = 1'b0;
  logic            exp_ready = 1'b0;
  logic [15:0]     exp_cnt = '0;
  logic            check_cnt = 1'b1;
  logic            last_load = 1'b0;
  logic            pushed = 1'b0;
  logic [2*PW-1:0] inc_val = 32'h0001_0000;
  stereo_t         smp;

  always #5 clk_gen_fast = ~clk_gen_fast;

  i2s_tx #(
    .DOWNSAMPLE (DS),
    .BITS       (NB),
    .PCM_W      (PW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_gen_fast (clk_gen_fast),
    .arstn        (arstn),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .mute         (mute),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  function automatic logic exp_sdata(input int b, input logic [2*PW-1:0] f);
    if (b >= 1 && b <= PW)         return f[2*PW-b];
    if (b >= NB + 1 && b <= NB + PW) return f[NB+PW-b];
    return 1'b0;
  endfunction

  function automatic int cur_bit();
    return (n / DS) % (2 * NB);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic checkAll();
    checkOutput("bclk", 32'(bclk), 32'((n % DS) >= DS / 2));
    checkOutput("lrclk", 32'(lrclk), 32'(cur_bit() >= NB));
    checkOutput("sdata", 32'(sdata), 32'(exp_sdata(cur_bit(), cur_frame)));
    checkOutput("underrun", 32'(underrun), 32'(exp_underrun));
    checkOutput("s_tready", 32'(s_tready), 32'(exp_ready));
    if (check_cnt) checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt));
  endtask

  // Called at a negedge: drive inputs, advance the model across one posedge, check at the next negedge.
  task automatic applyStimulus(input logic valid, input logic [2*PW-1:0] data, input logic mute_in);
    s_tvalid = valid;
    s_tdata  = data;
    mute     = mute_in;
    @(posedge clk_gen_fast);
    n++;
    last_load    = (n == 1) || (n % FRAME == 0);
    exp_underrun = 1'b0;
    pushed       = valid && exp_ready;
    if (last_load) begin
      if (q.size() == 0) begin
        cur_frame    = '0;
        exp_underrun = 1'b1;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else begin
        cur_frame = q.pop_front();
        if (mute_in) cur_frame = '0;
      end
    end
    if (pushed) q.push_back(data);
    exp_ready = (q.size() < DEPTH);
    @(negedge clk_gen_fast);
    checkAll();
  endtask

  task automatic modelReset();
    n = 0;
    q.delete();
    cur_frame    = '0;
    exp_underrun = 1'b0;
    exp_ready    = 1'b0;
    exp_cnt      = '0;
    last_load    = 1'b0;
  endtask

  initial begin
    // Reset state
    arstn = 1'b0;
    repeat (3) @(negedge clk_gen_fast);
    checkAll();
    arstn = 1'b1;

    // Idle: three underrun frames
    for (int i = 0; i < 3 * FRAME - 1; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("cnt_after_3_frames", 32'(underrun_cnt), 32'd3);

    // Single sample pushed in the load cycle of an empty FIFO
    smp.left  = 16'h8001;
    smp.right = 16'h7FFE;
    applyStimulus(1'b1, smp, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, '0, 1'b0);

    // Back-pressure with an incrementing pattern
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus(1'b1, inc_val, 1'b0);
      if (pushed) inc_val = inc_val + 32'h0001_0001;
    end

    // Mute across one frame load, then play the rest
    for (int i = 0; i < FRAME + 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (last_load) break;
    end
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, '0, 1'b0);

    // Random traffic and mute
    for (int i = 0; i < 5 * FRAME; i++)
      applyStimulus(($urandom_range(0, 299) == 0), $urandom, ($urandom_range(0, 7) == 0));

    // Reset at bit 20 with two samples queued
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (q.size() == 0) break;
      applyStimulus(1'b0, '0, 1'b0);
    end
    for (int i = 0; i < FRAME + 8; i++) begin
      if (cur_bit() == 1) break;
      applyStimulus(1'b0, '0, 1'b0);
    end
    applyStimulus(1'b1, $urandom, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      if (cur_bit() == 20) break;
      applyStimulus(1'b0, '0, 1'b0);
    end
    #2 arstn = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk_gen_fast);
    arstn = 1'b1;
    for (int i = 0; i < FRAME + 16; i++) applyStimulus(1'b0, '0, 1'b0);

    // Saturation of the underrun counter
    force dut.underrun_cnt = 16'hFFFE;
    exp_cnt   = 16'hFFFE;
    check_cnt = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (last_load) break;
    end
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    release dut.underrun_cnt;
    for (int i = 0; i < FRAME + 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (last_load) break;
    end
    check_cnt = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("cnt_saturated", 32'(underrun_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
